// File: rtl/sev_seg_pkg.sv
// sev_seg_pkg: seven-segment constants and the segment-to-hex decoder,
// shared by the display driver's encoder and the loopback decoder.
package sev_seg_pkg;
   localparam int SEG_W = 7;
   localparam logic [SEG_W-1:0] HEX_SEG [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   // Takes the active-low bus pattern; ok is low when it matches no hex glyph.
   function automatic logic [3:0] seg_to_hex(input logic [SEG_W-1:0] seg_n, output logic ok);
      logic [3:0] v;
      v = '0;
      ok = 1'b0;
      for (int i = 0; i < 16; i++)
         if (~seg_n == HEX_SEG[i]) begin
            v = 4'(i);
            ok = 1'b1;
         end
      return v;
   endfunction
endpackage

// File: rtl/sev_seg_digit_capture.sv
// sev_seg_digit_capture: per-digit stability filter, hex decode and staleness
// tracking for one multiplexed digit.
module sev_seg_digit_capture
   import sev_seg_pkg::*;
#(
   parameter int STABLE_CNT = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             active,
   input  logic             clear,
   input  logic [SEG_W-1:0] seg_n,
   output logic [3:0]       digit,
   output logic             valid,
   output logic             upd,
   output logic             err
);
   localparam int CW = $clog2(STABLE_CNT + 1);
   localparam int AW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
   localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CNT - 1);
   localparam logic [AW-1:0] AGE_MAX = AW'(TIMEOUT);
   localparam logic [AW-1:0] AGE_PRE = AW'(TIMEOUT - 1);

   logic [SEG_W-1:0] cand;
   logic [CW-1:0]    cnt;
   logic [AW-1:0]    age;
   logic             match, accept, ok, stale;
   logic [3:0]       value;

   // accept fires only on the tick the run length reaches STABLE_CNT, never while saturated
   always_comb begin
      match  = seg_n == cand;
      accept = active && (match ? cnt == CNT_PRE : STABLE_CNT == 1);
      stale  = age >= AGE_PRE;
      value  = seg_to_hex(seg_n, ok);
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cand  <= '0;
         cnt   <= '0;
         age   <= '0;
         digit <= '0;
         valid <= 1'b0;
         upd   <= 1'b0;
         err   <= 1'b0;
      end else begin
         upd <= 1'b0;
         err <= 1'b0;
         if (tick && active) begin
            age  <= '0;
            cand <= seg_n;
            cnt  <= !match ? CW'(1) : cnt == CNT_MAX ? cnt : cnt + CW'(1);
            if (accept && ok) begin
               digit <= value;
               valid <= 1'b1;
               upd   <= value != digit || !valid;
            end else if (accept) begin
               err <= 1'b1;
            end
         end else if (tick) begin
            age <= age == AGE_MAX ? age : age + AW'(1);
            if (clear || stale)
               cnt <= '0;
            if (stale)
               valid <= 1'b0;
         end
      end
endmodule

// File: rtl/sev_seg_mux_decoder.sv
// sev_seg_mux_decoder: receive end of the dual-digit multiplexed seven-segment
// bus; synchronises, samples and demultiplexes into two filtered hex digits.
module sev_seg_mux_decoder
   import sev_seg_pkg::*;
#(
   parameter int SAMPLE_DIV = 4,
   parameter int STABLE_CNT = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [SEG_W-1:0] seg_n,
   input  logic [1:0]       an_n,
   output logic [3:0]       digit0,
   output logic [3:0]       digit1,
   output logic [1:0]       valid,
   output logic [1:0]       upd,
   output logic             err
);
   localparam int PW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [PW-1:0] PS_MAX = PW'(SAMPLE_DIV - 1);

   logic [SEG_W-1:0] seg_s1, seg_s2;
   logic [1:0]       an_s1, an_s2, active, dig_err;
   logic [PW-1:0]    ps;
   logic             tick, illegal, ill_err;

   // synchronisers reset to the blank bus level so start-up samples raise no error
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         seg_s1  <= '1;
         seg_s2  <= '1;
         an_s1   <= '1;
         an_s2   <= '1;
         ps      <= '0;
         ill_err <= 1'b0;
      end else begin
         seg_s1  <= seg_n;
         seg_s2  <= seg_s1;
         an_s1   <= an_n;
         an_s2   <= an_s1;
         ps      <= tick ? '0 : ps + PW'(1);
         ill_err <= tick && illegal;
      end

   always_comb begin
      tick      = ps == PS_MAX;
      active[0] = tick && an_s2 == 2'b10;
      active[1] = tick && an_s2 == 2'b01;
      illegal   = an_s2 == 2'b00;
      err       = ill_err || |dig_err;
   end

   sev_seg_digit_capture #(.STABLE_CNT(STABLE_CNT), .TIMEOUT(TIMEOUT)) u_dig0 (
      .clk(clk), .reset(reset), .tick(tick), .active(active[0]), .clear(illegal),
      .seg_n(seg_s2), .digit(digit0), .valid(valid[0]), .upd(upd[0]), .err(dig_err[0]));

   sev_seg_digit_capture #(.STABLE_CNT(STABLE_CNT), .TIMEOUT(TIMEOUT)) u_dig1 (
      .clk(clk), .reset(reset), .tick(tick), .active(active[1]), .clear(illegal),
      .seg_n(seg_s2), .digit(digit1), .valid(valid[1]), .upd(upd[1]), .err(dig_err[1]));
endmodule

// File: tb/tb_sev_seg_mux_decoder.sv
// tb_sev_seg_mux_decoder: directed scenarios with hand-computed expectations
// (SAMPLE_DIV=1, STABLE_CNT=4, TIMEOUT=16); edge e counts posedges after a drive.
module tb_sev_seg_mux_decoder;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] seg_n = '1;
   logic [1:0] an_n = 2'b11;
   logic [3:0] digit0, digit1;
   logic [1:0] valid, upd;
   logic       err;
   int checks = 0;
   int failures = 0;

   sev_seg_mux_decoder #(.SAMPLE_DIV(1), .STABLE_CNT(4), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .seg_n(seg_n), .an_n(an_n),
      .digit0(digit0), .digit1(digit1), .valid(valid), .upd(upd), .err(err));

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (3) step();
      checks++; if (digit0 !== 4'h0) begin failures++; $display("FAIL reset_digit0 got=%h exp=0", digit0); end
      checks++; if (digit1 !== 4'h0) begin failures++; $display("FAIL reset_digit1 got=%h exp=0", digit1); end
      checks++; if (valid !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b exp=00", valid); end
      checks++; if (upd !== 2'b00) begin failures++; $display("FAIL reset_upd got=%b exp=00", upd); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      reset = 1'b0;
   endtask

   task automatic test_single();
      an_n = 2'b10;
      seg_n = ~7'h5B;
      for (int e = 1; e <= 8; e++) begin
         step();
         checks++; if (upd !== {1'b0, e == 6}) begin failures++; $display("FAIL single_upd e=%0d got=%b exp=%b", e, upd, {1'b0, e == 6}); end
         checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err e=%0d got=%b exp=0", e, err); end
      end
      checks++; if (digit0 !== 4'h2) begin failures++; $display("FAIL single_digit0 got=%h exp=2", digit0); end
      checks++; if (valid !== 2'b01) begin failures++; $display("FAIL single_valid got=%b exp=01", valid); end
   endtask

   task automatic test_reset_mid();
      seg_n = ~7'h66;
      repeat (5) step();
      #2 reset = 1'b1;
      #1;
      checks++; if (digit0 !== 4'h0) begin failures++; $display("FAIL midrst_digit0 got=%h exp=0", digit0); end
      checks++; if (valid !== 2'b00) begin failures++; $display("FAIL midrst_valid got=%b exp=00", valid); end
      checks++; if (upd !== 2'b00 || err !== 1'b0) begin failures++; $display("FAIL midrst_pulses got=%b%b exp=000", upd, err); end
      @(negedge clk) reset = 1'b0;
      for (int e = 1; e <= 7; e++) begin
         step();
         checks++; if (upd !== {1'b0, e == 6}) begin failures++; $display("FAIL midrst_upd e=%0d got=%b exp=%b", e, upd, {1'b0, e == 6}); end
      end
      checks++; if (digit0 !== 4'h4 || valid !== 2'b01) begin failures++; $display("FAIL midrst_accept got=%h/%b exp=4/01", digit0, valid); end
   endtask

   task automatic test_interleave();
      for (int c = 0; c < 20; c++) begin
         an_n = (c % 2 == 1) ? 2'b01 : 2'b10;
         seg_n = (c % 2 == 1) ? ~7'h06 : ~7'h79;
         step();
         checks++; if (err !== 1'b0) begin failures++; $display("FAIL inter_err c=%0d got=%b exp=0", c, err); end
      end
      checks++; if (digit0 !== 4'hE) begin failures++; $display("FAIL inter_digit0 got=%h exp=e", digit0); end
      checks++; if (digit1 !== 4'h1) begin failures++; $display("FAIL inter_digit1 got=%h exp=1", digit1); end
      checks++; if (valid !== 2'b11) begin failures++; $display("FAIL inter_valid got=%b exp=11", valid); end
   endtask

   task automatic test_bad_pattern();
      an_n = 2'b10;
      seg_n = ~7'h01;
      for (int e = 1; e <= 10; e++) begin
         step();
         checks++; if (err !== (e == 6)) begin failures++; $display("FAIL bad_err e=%0d got=%b exp=%b", e, err, e == 6); end
         checks++; if (upd[0] !== 1'b0) begin failures++; $display("FAIL bad_upd e=%0d got=%b exp=0", e, upd[0]); end
      end
      checks++; if (digit0 !== 4'hE || valid[0] !== 1'b1) begin failures++; $display("FAIL bad_hold got=%h/%b exp=e/1", digit0, valid[0]); end
   endtask

   task automatic test_illegal();
      seg_n = ~7'h06;
      for (int e = 1; e <= 12; e++) begin
         an_n = (e == 4) ? 2'b00 : 2'b10;
         step();
         checks++; if (err !== (e == 6)) begin failures++; $display("FAIL illegal_err e=%0d got=%b exp=%b", e, err, e == 6); end
         checks++; if (upd[0] !== (e == 10)) begin failures++; $display("FAIL illegal_upd e=%0d got=%b exp=%b", e, upd[0], e == 10); end
      end
      checks++; if (digit0 !== 4'h1) begin failures++; $display("FAIL illegal_digit0 got=%h exp=1", digit0); end
   endtask

   task automatic test_timeout();
      an_n = 2'b01;
      seg_n = ~7'h4F;
      for (int e = 1; e <= 8; e++) begin
         step();
         checks++; if (upd[1] !== (e == 6)) begin failures++; $display("FAIL tmo_acc_upd e=%0d got=%b exp=%b", e, upd[1], e == 6); end
      end
      an_n = 2'b10;
      seg_n = ~7'h5B;
      for (int e = 1; e <= 19; e++) begin
         step();
         checks++; if (valid[1] !== (e < 18)) begin failures++; $display("FAIL tmo_valid e=%0d got=%b exp=%b", e, valid[1], e < 18); end
         checks++; if (digit1 !== 4'h3) begin failures++; $display("FAIL tmo_digit1 e=%0d got=%h exp=3", e, digit1); end
      end
      an_n = 2'b01;
      seg_n = ~7'h4F;
      for (int e = 1; e <= 8; e++) begin
         step();
         checks++; if (upd[1] !== (e == 6)) begin failures++; $display("FAIL tmo_reacc_upd e=%0d got=%b exp=%b", e, upd[1], e == 6); end
      end
      checks++; if (valid[1] !== 1'b1 || digit1 !== 4'h3) begin failures++; $display("FAIL tmo_reacc got=%b/%h exp=1/3", valid[1], digit1); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_reset_mid();
      test_interleave();
      test_bad_pattern();
      test_illegal();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
